// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-write-side signal bundle for fifo_wr_arbiter.
// The slave modport is the arbiter's view; the master modport drives requesters and WR_FULL.
interface fifo_wr_arbiter_if #(
  parameter int C_WIDTH   = 32,
  parameter int C_NUM_REQ = 4
);
  logic [C_NUM_REQ*C_WIDTH-1:0] S_DATA;
  logic [C_NUM_REQ-1:0]         S_VALID;
  logic [C_NUM_REQ-1:0]         S_LAST;
  logic [C_NUM_REQ-1:0]         S_READY;
  logic [C_WIDTH-1:0]           WR_DATA;
  logic                         WR_EN;
  logic                         WR_FULL;
  logic [C_NUM_REQ-1:0]         GRANT;
  logic                         BUSY;

  modport slave (
    input  S_DATA, S_VALID, S_LAST, WR_FULL,
    output S_READY, WR_DATA, WR_EN, GRANT, BUSY
  );

  modport master (
    output S_DATA, S_VALID, S_LAST, WR_FULL,
    input  S_READY, WR_DATA, WR_EN, GRANT, BUSY
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO write port among C_NUM_REQ requesters.
// Define FIFO_WR_ARB_STATS_EN to add per-requester packet counters (PKT_CNT, CNT_CLR).
module fifo_wr_arbiter #(
  parameter int C_WIDTH    = 32,
  parameter int C_NUM_REQ  = 4,
  parameter int C_REQ_BITS = $clog2(C_NUM_REQ)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
`ifdef FIFO_WR_ARB_STATS_EN
  input  logic                   CNT_CLR,
  output logic [C_NUM_REQ*16-1:0] PKT_CNT,
`endif
  fifo_wr_arbiter_if.slave       bus
);

  // IDLE | arbitrating among pending requesters, no beat accepted
  // XFER | granted owner streams beats straight into the FIFO until its LAST beat
  typedef enum logic {IDLE, XFER} state_t;

  state_t                state_q, state_d;
  logic [C_REQ_BITS-1:0] gidx_q, gidx_d;
  logic [C_REQ_BITS-1:0] last_q, last_d;
  logic [C_NUM_REQ-1:0]  grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic [C_REQ_BITS-1:0] pick, cand;
  logic                  pick_vld;
  logic                  accept, done;
  logic [C_WIDTH-1:0]    s_data_arr [C_NUM_REQ];

  for (genvar i = 0; i < C_NUM_REQ; i++) begin : g_slice
    assign s_data_arr[i] = bus.S_DATA[i*C_WIDTH +: C_WIDTH];
  end

  // First pending requester strictly after the last owner, with wrap-around.
  always_comb begin
    pick     = last_q;
    cand     = last_q;
    pick_vld = 1'b0;
    for (int k = 1; k <= C_NUM_REQ; k++) begin
      cand = C_REQ_BITS'((int'(last_q) + k) % C_NUM_REQ);
      if (!pick_vld && bus.S_VALID[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    bus.S_READY = '0;
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = '0;
    if (state_q == XFER) begin
      bus.S_READY[gidx_q] = !bus.WR_FULL;
      bus.WR_EN           = bus.S_VALID[gidx_q] & !bus.WR_FULL;
      bus.WR_DATA         = s_data_arr[gidx_q];
    end
  end

  assign accept    = (state_q == XFER) & bus.S_VALID[gidx_q] & !bus.WR_FULL;
  assign done      = accept & bus.S_LAST[gidx_q];
  assign bus.GRANT = grant_q;
  assign bus.BUSY  = busy_q;

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = XFER;
          gidx_d  = pick;
          grant_d = C_NUM_REQ'(1) << pick;
          busy_d  = 1'b1;
        end
      end
      XFER: begin
        if (done) begin
          state_d = IDLE;
          last_d  = gidx_q;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      last_q  <= C_REQ_BITS'(C_NUM_REQ - 1);
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] cnt_q [C_NUM_REQ];

  // Clear wins over a same-cycle packet completion.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < C_NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (CNT_CLR) begin
      for (int i = 0; i < C_NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (done) begin
      cnt_q[gidx_q] <= cnt_q[gidx_q] + 16'd1;
    end
  end

  for (genvar i = 0; i < C_NUM_REQ; i++) begin : g_cnt
    assign PKT_CNT[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter: per-requester expected-beat queues
// and a round-robin reference checked by a negedge monitor.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic clk;
  logic rst_n;
  logic cnt_clr;
  logic [N*16-1:0] pkt_cnt;

  fifo_wr_arbiter_if #(.C_WIDTH(W), .C_NUM_REQ(N)) bus ();

  fifo_wr_arbiter #(.C_WIDTH(W), .C_NUM_REQ(N)) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
`ifdef FIFO_WR_ARB_STATS_EN
    .CNT_CLR (cnt_clr),
    .PKT_CNT (pkt_cnt),
`endif
    .bus     (bus)
  );

`ifndef FIFO_WR_ARB_STATS_EN
  assign pkt_cnt = '0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  beat_t        src_q [N][$];
  logic [W-1:0] exp_q [N][$];
  logic [W-1:0] drv_data [N];
  int           hold_off [N];
  int           bubble_pct = 0;
  int           full_pct = 0;
  logic         full_pat [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arbitration rule: first pending requester after the last owner, wrapping.
  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic load_pkt(input int r, input int len, input bit fixed, input logic [W-1:0] base);
    for (int b = 0; b < len; b++) begin
      beat_t bt;
      bt.d = fixed ? base + W'(b) : W'($urandom);
      bt.l = (b == len - 1);
      src_q[r].push_back(bt);
      exp_q[r].push_back(bt.d);
    end
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Requester drivers: present queue heads, drop beats the DUT accepted.
  initial begin
    logic [N-1:0] acc;
    bus.S_VALID = '0;
    bus.S_LAST  = '0;
    bus.S_DATA  = '0;
    bus.WR_FULL = 1'b0;
    for (int i = 0; i < N; i++) begin
      drv_data[i] = '0;
      hold_off[i] = 0;
    end
    forever begin
      @(negedge clk);
      acc = bus.S_VALID & bus.S_READY;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0 && hold_off[i] == 0 &&
            $urandom_range(99) >= 32'(bubble_pct)) begin
          bus.S_VALID[i] = 1'b1;
          bus.S_LAST[i]  = src_q[i][0].l;
          drv_data[i]    = src_q[i][0].d;
        end else begin
          bus.S_VALID[i] = 1'b0;
          bus.S_LAST[i]  = 1'($urandom_range(1));
          drv_data[i]    = W'($urandom);
        end
        if (hold_off[i] > 0) hold_off[i]--;
        bus.S_DATA[i*W +: W] = drv_data[i];
      end
      if (full_pat.size() > 0) bus.WR_FULL = full_pat.pop_front();
      else bus.WR_FULL = ($urandom_range(99) < 32'(full_pct));
    end
  end

  // Monitor / scoreboard
  int           m_last;
  logic         m_idle, m_done;
  logic [N-1:0] m_vld, m_grant;
  logic [15:0]  mcnt [N];

  always @(negedge clk) begin
    logic [N-1:0] exp_gnt;
    logic         done;
    int           g;
    logic [N*16-1:0] mpk;
    if (!rst_n) begin
      m_last  = N - 1;
      m_idle  = 1'b1;
      m_done  = 1'b0;
      m_vld   = '0;
      m_grant = '0;
      for (int i = 0; i < N; i++) mcnt[i] = '0;
    end else begin
      if (m_idle) begin
        exp_gnt = '0;
        if (m_vld != '0) exp_gnt[rr_pick(m_last, m_vld)] = 1'b1;
        chk("grant_arb", 64'(bus.GRANT), 64'(exp_gnt));
      end else if (m_done) begin
        chk("grant_release", 64'({bus.GRANT, bus.BUSY}), 64'd0);
      end else begin
        chk("grant_hold", 64'(bus.GRANT), 64'(m_grant));
      end
      chk("busy", 64'(bus.BUSY), 64'(bus.GRANT != '0));
      chk("no_wr_when_full", 64'(bus.WR_EN & bus.WR_FULL), 64'd0);
      done = 1'b0;
      g = 0;
      if (bus.GRANT == '0) begin
        chk("idle_outputs", 64'({bus.S_READY, bus.WR_EN, bus.WR_DATA}), 64'd0);
      end else begin
        for (int i = N - 1; i >= 0; i--) if (bus.GRANT[i]) g = i;
        chk("grant_onehot", 64'($countones(bus.GRANT)), 64'd1);
        chk("s_ready", 64'(bus.S_READY), bus.WR_FULL ? 64'd0 : 64'(bus.GRANT));
        chk("wr_en", 64'(bus.WR_EN), 64'(bus.S_VALID[g] & !bus.WR_FULL));
        chk("wr_data_path", 64'(bus.WR_DATA), 64'(drv_data[g]));
        if (bus.WR_EN) begin
          if (exp_q[g].size() == 0) begin
            chk("unexpected_write", 64'(bus.WR_DATA), 64'hDEAD_0000_0000_0000);
          end else begin
            chk("fifo_data", 64'(bus.WR_DATA), 64'(exp_q[g].pop_front()));
          end
          done = bus.S_LAST[g];
        end
      end
`ifdef FIFO_WR_ARB_STATS_EN
      for (int i = 0; i < N; i++) mpk[i*16 +: 16] = mcnt[i];
      chk("pkt_cnt", 64'(pkt_cnt), 64'(mpk));
      if (cnt_clr) begin
        for (int i = 0; i < N; i++) mcnt[i] = '0;
      end else if (done) begin
        mcnt[g] = mcnt[g] + 16'd1;
      end
`else
      mpk = '0;
`endif
      m_idle  = (bus.GRANT == '0);
      m_vld   = bus.S_VALID;
      m_done  = done;
      m_grant = bus.GRANT;
      if (done) m_last = g;
    end
  end

  task automatic drain(input string name, input int maxc);
    int c;
    c = 0;
    while (c < maxc && !(srcs_empty() && bus.GRANT == '0)) begin
      @(posedge clk);
      #2;
      c++;
    end
    if (c >= maxc) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: drain timeout, grant %0h, required idle within %0d cycles", name, bus.GRANT, maxc);
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(input string name, input int r, input int maxc);
    int c;
    c = 0;
    while (c < maxc && !bus.GRANT[r]) begin
      @(posedge clk);
      #2;
      c++;
    end
    if (c >= maxc) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: grant %0h, required bit %0d within %0d cycles", name, bus.GRANT, r, maxc);
    end
  endtask

  initial begin
    int tot;
    rst_n   = 1'b0;
    cnt_clr = 1'b0;
    #12;
    chk("reset_state", 64'({bus.GRANT, bus.BUSY, bus.S_READY, bus.WR_EN, bus.WR_DATA}), 64'd0);
    #10 rst_n = 1'b1;

    // Single requester, fixed data 0xA0..0xA2
    @(posedge clk); #2;
    load_pkt(1, 3, 1'b1, 32'hA0);
    drain("single", 100);

    // Backpressure on a 4-beat packet
    load_pkt(2, 4, 1'b0, '0);
    wait_grant("bp_grant", 2, 50);
    full_pat.push_back(1'b1);
    full_pat.push_back(1'b1);
    full_pat.push_back(1'b1);
    drain("backpressure", 100);

    // Owner bubble while requester 3 waits
    load_pkt(1, 4, 1'b0, '0);
    wait_grant("bubble_grant", 1, 50);
    load_pkt(3, 2, 1'b0, '0);
    hold_off[1] = 3;
    drain("bubble", 100);

    // Reset in the middle of a 3-beat packet
    load_pkt(1, 3, 1'b0, '0);
    begin
      int c;
      c = 0;
      while (c < 50 && exp_q[1].size() != 2) begin
        @(posedge clk);
        c++;
      end
      chk("reset_first_beat", 64'(exp_q[1].size()), 64'd2);
    end
    #3 rst_n = 1'b0;
    #1;
    chk("reset_async", 64'({bus.GRANT, bus.BUSY, bus.WR_EN}), 64'd0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Round-robin after reset: 0, 2, 3
    load_pkt(0, 2, 1'b0, '0);
    load_pkt(2, 2, 1'b0, '0);
    load_pkt(3, 2, 1'b0, '0);
    wait_grant("rr_first", 0, 5);
    drain("round_robin", 100);

`ifdef FIFO_WR_ARB_STATS_EN
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int p = 0; p < 5; p++) load_pkt(2, 1 + p % 3, 1'b0, '0);
    drain("stats", 200);
    chk("stats_five", 64'(pkt_cnt), 64'h0000_0005_0000_0000);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(posedge clk); #2;
    chk("stats_clear", 64'(pkt_cnt), 64'd0);
`endif

    // Randomized traffic with bubbles and backpressure
    for (int r = 0; r < 30; r++) begin
      bubble_pct = int'($urandom_range(0, 40));
      full_pct   = int'($urandom_range(0, 40));
      for (int p = 0; p < int'($urandom_range(1, 6)); p++)
        load_pkt(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 5)), 1'b0, '0);
      repeat ($urandom_range(0, 15)) @(posedge clk);
      #2;
      for (int p = 0; p < int'($urandom_range(0, 3)); p++)
        load_pkt(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 5)), 1'b0, '0);
      drain("random", 3000);
    end
    bubble_pct = 0;
    full_pct   = 0;

    tot = 0;
    for (int i = 0; i < N; i++) tot += exp_q[i].size();
    chk("leftover_beats", 64'(tot), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
